// File: rtl/obj_frame_sequencer.sv
// obj_frame_sequencer: periodic snapshot of object locations, streamed out one word per valid/ready handshake
module obj_frame_sequencer #(
    parameter int NUM_OBJ   = 6,
    parameter int LOC_WIDTH = 21,
    parameter int PERIOD    = 10000,
    parameter int OVR_WIDTH = 8,
    localparam int IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic                         changed_only_in,
    input  logic [NUM_OBJ*LOC_WIDTH-1:0] obj_loc_in,
    output logic                         out_valid_out,
    input  logic                         out_ready_in,
    output logic [LOC_WIDTH-1:0]         out_data_out,
    output logic [IDX_W-1:0]             out_idx_out,
    output logic                         out_last_out,
    output logic                         frame_done_out,
    output logic [OVR_WIDTH-1:0]         overrun_count_out
);
    localparam int CNT_W = $clog2(PERIOD);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LOC_WIDTH-1:0]   snap_q [NUM_OBJ];
    logic [LOC_WIDTH-1:0]   snap_d [NUM_OBJ];
    logic [LOC_WIDTH-1:0]   prev_q [NUM_OBJ];
    logic [LOC_WIDTH-1:0]   prev_d [NUM_OBJ];
    logic [NUM_OBJ-1:0]     mask_q, mask_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LOC_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic [OVR_WIDTH-1:0]   ovr_q, ovr_d;
    logic                   tick, hs;

    always_comb begin
        tick    = enable_in && (cnt_q == CNT_W'(PERIOD - 1));
        hs      = valid_q && out_ready_in;
        cnt_d   = (!enable_in || tick) ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        snap_d  = snap_q;
        prev_d  = prev_q;
        mask_d  = mask_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (tick) begin
                for (int k = 0; k < NUM_OBJ; k++) begin
                    snap_d[k] = obj_loc_in[k*LOC_WIDTH +: LOC_WIDTH];
                    mask_d[k] = !changed_only_in || (obj_loc_in[k*LOC_WIDTH +: LOC_WIDTH] != prev_q[k]);
                end
                state_d = (|mask_d) ? STREAM : IDLE;
                done_d  = ~|mask_d;
            end
        end else begin
            if (tick)
                ovr_d = (&ovr_q) ? ovr_q : ovr_q + 1'b1;
            if (hs) begin
                prev_d[idx_q] = snap_q[idx_q];
                mask_d[idx_q] = 1'b0;
                state_d       = last_q ? IDLE : STREAM;
                done_d        = last_q;
            end
        end
        // bits below idx are always clear while streaming, so the lowest set bit is the next word
        idx_d = '0;
        for (int k = NUM_OBJ - 1; k >= 0; k--)
            if (mask_d[k])
                idx_d = IDX_W'(k);
        valid_d = (state_d == STREAM);
        last_d  = valid_d;
        for (int k = 0; k < NUM_OBJ; k++)
            if (mask_d[k] && k > int'(idx_d))
                last_d = 1'b0;
        data_d = valid_d ? snap_d[idx_d] : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '{default: '0};
            prev_q  <= '{default: '0};
            mask_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid_out     = valid_q;
    assign out_data_out      = data_q;
    assign out_idx_out       = idx_q;
    assign out_last_out      = last_q;
    assign frame_done_out    = done_q;
    assign overrun_count_out = ovr_q;
endmodule

// File: tb/tb_obj_frame_sequencer.sv
// tb_obj_frame_sequencer: directed and random stimulus checked cycle by cycle against a queue-based frame model
module tb_obj_frame_sequencer;
    localparam int N  = 6;
    localparam int LW = 21;
    localparam int P  = 8;
    localparam int OW = 2;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst, en, co, ready;
    logic [N*LW-1:0] loc;
    logic            out_valid, out_last, frame_done;
    logic [LW-1:0]   out_data;
    logic [IW-1:0]   out_idx;
    logic [OW-1:0]   ovr;

    int total = 0;
    int bad   = 0;

    obj_frame_sequencer #(.NUM_OBJ(N), .LOC_WIDTH(LW), .PERIOD(P), .OVR_WIDTH(OW)) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en), .changed_only_in(co),
        .obj_loc_in(loc), .out_valid_out(out_valid), .out_ready_in(ready),
        .out_data_out(out_data), .out_idx_out(out_idx), .out_last_out(out_last),
        .frame_done_out(frame_done), .overrun_count_out(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [LW-1:0] data;
    } word_t;

    word_t         q[$];
    logic [LW-1:0] prev [N];
    int            m_cnt = 0;
    int            m_ovr = 0;
    bit            m_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] loc_of(input int k);
        return loc[k*LW +: LW];
    endfunction

    task automatic model_step();
        bit    t;
        word_t w;
        if (rst) begin
            q.delete();
            for (int k = 0; k < N; k++) prev[k] = '0;
            m_cnt  = 0;
            m_ovr  = 0;
            m_done = 0;
        end else begin
            t      = en && (m_cnt == P - 1);
            m_cnt  = (!en || t) ? 0 : m_cnt + 1;
            m_done = 0;
            if (q.size() != 0) begin
                if (t && m_ovr < (1 << OW) - 1) m_ovr++;
                if (ready) begin
                    w = q.pop_front();
                    prev[w.idx] = w.data;
                    m_done = (q.size() == 0);
                end
            end else if (t) begin
                for (int k = 0; k < N; k++)
                    if (!co || loc_of(k) != prev[k]) q.push_back('{k, loc_of(k)});
                m_done = (q.size() == 0);
            end
        end
    endtask

    task automatic compare();
        check("valid", 32'(out_valid), 32'(q.size() != 0));
        check("done", 32'(frame_done), 32'(m_done));
        check("ovr", 32'(ovr), 32'(m_ovr));
        if (q.size() != 0) begin
            check("data", 32'(out_data), 32'(q[0].data));
            check("idx", 32'(out_idx), 32'(q[0].idx));
            check("last", 32'(out_last), 32'(q.size() == 1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        int n3, stall, found;
        rst = 1'b1; en = 1'b0; co = 1'b0; ready = 1'b1; loc = '0;
        step();
        step();
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < N; k++) loc[k*LW +: LW] = LW'(k + 1);
        // full frame: tick at edge 7, words follow, last on idx 5, done after edge 13
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 6) check("pre_tick_valid", 32'(out_valid), 32'd0);
            if (i == 7) check("first_idx0", 32'({out_valid, out_idx}), 32'({1'b1, 3'd0}));
            if (i == 12) check("last_idx5", 32'({out_last, out_idx}), 32'({1'b1, 3'd5}));
            if (i == 13) check("done_after_full", 32'(frame_done), 32'd1);
        end
        co = 1'b1;
        loc[2*LW +: LW] = 21'h1FFFFF;
        loc[4*LW +: LW] = 21'h1FFFFF;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("delta_idx2", 32'({out_valid, out_last, out_idx}), 32'({2'b10, 3'd2}));
            if (i == 1) check("delta_idx4", 32'({out_valid, out_last, out_idx}), 32'({2'b11, 3'd4}));
            if (i == 2) check("delta_done", 32'(frame_done), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("empty_done", 32'({out_valid, frame_done}), 32'b01);
        end
        co = 1'b0; n3 = 0; stall = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid && out_idx == 3 && stall < 5) begin
                ready = 1'b0;
                stall++;
            end else ready = 1'b1;
            if (out_valid && ready && out_idx == 3) n3++;
            step();
        end
        check("idx3_once", 32'(n3), 32'd1);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("ovr_sat", 32'(ovr), 32'd3);
        ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) loc[k*LW +: LW] = LW'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        ready = 1'b1;
        for (int k = 0; k < N; k++) loc[k*LW +: LW] = LW'($urandom_range(1, 1000));
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (out_valid && out_idx == 2) found = 1;
        end
        check("reach_idx2", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_outs", 32'({out_valid, out_last, out_idx, frame_done, ovr}), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        co  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) co = ~co;
            if ($urandom_range(0, 4) == 0)
                loc[$urandom_range(0, N - 1)*LW +: LW] = LW'($urandom_range(0, 7));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obj_frame_sequencer.md
# obj_frame_sequencer

Periodic snapshot-and-stream engine for game-object locations. Every `PERIOD` cycles it atomically captures all `NUM_OBJ` packed location words into a shadow buffer. It then streams them out one per valid/ready handshake, tagging each word with its object index and a last flag. In delta mode it emits only objects whose location changed since the last emitted value. It sits between the host-register bank and the display pipeline, replacing the free-running tick that previously drove display input directly.

## Interface
- `NUM_OBJ`, default 6: number of objects; ≥1.
- `LOC_WIDTH`, default 21: bits per packed location word.
- `PERIOD`, default 10000: snapshot interval in clock cycles; ≥2.
- `OVR_WIDTH`, default 8: overrun counter width.
- `IDX_W` (localparam): max(1, $clog2(NUM_OBJ)).

Ports:
- `clk_in`, input, 1: single clock; all logic on its rising edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `enable_in`, input, 1: period counter runs when high.
- `changed_only_in`, input, 1: delta mode select; sampled at snapshot.
- `obj_loc_in`, input, NUM_OBJ×LOC_WIDTH: live locations; object k is at bits [k*LOC_WIDTH +: LOC_WIDTH].
- `out_valid_out`, output, 1: an output word is presented.
- `out_ready_in`, input, 1: downstream accepts the word.
- `out_data_out`, output, LOC_WIDTH: snapshot location.
- `out_idx_out`, output, IDX_W: object index of `out_data_out`.
- `out_last_out`, output, 1: final word of the current frame.
- `frame_done_out`, output, 1: one-cycle pulse at frame end.
- `overrun_count_out`, output, OVR_WIDTH: number of dropped ticks; saturates.

## Operation
- Period counter `cnt`, 0..PERIOD-1.
  - Runs only while `enable_in`=1.
  - When `enable_in`=0: `cnt` is held at 0.
  - A tick occurs on the cycle where `cnt`==PERIOD-1 with `enable_in`=1; `cnt` wraps to 0 on that cycle.
- States: IDLE, STREAM.
- IDLE + tick:
  - `snap[k]` <= `obj_loc_in[k]` for all k, captured on the same edge.
  - `mask[k]` <= 1 if `changed_only_in`=0, otherwise (`obj_loc_in[k]` != `prev[k]`).
  - `idx` <= lowest set bit of the new mask.
  - Mask nonzero: go to STREAM.
  - Mask zero: stay in IDLE, pulse `frame_done_out` on the next cycle, emit no words.
- STREAM:
  - `out_valid_out`=1; `out_data_out`=`snap[idx]`; `out_idx_out`=`idx`.
  - `out_last_out`=1 iff no mask bit above `idx` is set.
  - On a handshake (`out_valid_out` && `out_ready_in`):
    - `prev[idx]` <= `snap[idx]`; clear `mask[idx]`.
    - If not last: `idx` <= next set bit above `idx`.
    - If last: go to IDLE; `frame_done_out`=1 on the following cycle.
  - Without `out_ready_in`: data, idx, last and valid all hold stable. Valid never drops before the handshake.
- Tick while in STREAM:
  - The tick is dropped; snapshot and mask are untouched.
  - `overrun_count_out` increments, saturating at 2^OVR_WIDTH−1.
  - The counter keeps running.
- `enable_in` falling mid-frame: the current frame completes normally.
- `prev` updates only for emitted objects. In full mode every object is emitted, so `prev` tracks all objects.
- `obj_loc_in` changes after the snapshot edge do not affect the frame in progress.
- All outputs are driven from registers; there is no combinational path from `obj_loc_in` or `out_ready_in` to any output.

## Timing
- Reset (synchronous), then on the next edge:
  - State = IDLE; `cnt`=0; `mask`=0; `idx`=0; `snap`=0; `prev`=0.
  - `out_valid_out`=0; `out_data_out`=0; `out_idx_out`=0; `out_last_out`=0.
  - `frame_done_out`=0; `overrun_count_out`=0.
- Reset asserted mid-frame aborts the frame. No `frame_done_out` pulse is produced, and `prev` is cleared.
- Tick on cycle T: `out_valid_out`=1 on cycle T+1 with the first selected object.
- Throughput: one word per cycle while `out_ready_in`=1. A full-mode frame takes NUM_OBJ cycles of STREAM.
- Last handshake on cycle L:
  - `out_valid_out`=0 at L+1.
  - `frame_done_out`=1 at L+1 only.
- Empty delta frame (tick at T): `frame_done_out`=1 at T+1.
- A tick on the same cycle as the last handshake counts as an overrun and is dropped. The next snapshot comes PERIOD cycles later.
- First tick after reset or enable: PERIOD-1 cycles after `enable_in` rises.

## Test plan
- **Full mode**, PERIOD=8, NUM_OBJ=6, locations 1..6, ready tied high, enable set at cycle 0:
  - Tick at cycle 7.
  - Valid on cycles 8..13 with idx 0..5 and data 1..6.
  - Last high only on idx 5; `frame_done_out` pulses at cycle 14.
- **Delta mode**, after one full frame, change objects 2 and 4 to 0x1FFFFF:
  - The next frame emits idx 2 then idx 4, with last on idx 4.
  - A following frame with no changes emits nothing, and `frame_done_out` pulses on the cycle after the tick.
- **Backpressure**: ready low for 5 cycles on idx 3.
  - Data, idx, last and valid stay constant through the stall.
  - Idx 3 is emitted exactly once when ready rises.
- **Overrun**: PERIOD=8 with ready held low for 20 cycles.
  - `overrun_count_out`=2 when ready rises.
  - With OVR_WIDTH=2 and 5 overruns, the count reads 3 (saturated).
- **Snapshot isolation**: change `obj_loc_in` every cycle during STREAM.
  - Emitted data equals the values present at the tick edge.
- **Reset mid-frame**: assert `rst_in` during idx 2 of a frame.
  - All outputs are 0 the next cycle; no `frame_done_out` pulse.
  - The next delta frame treats `prev` as 0, so every nonzero object is emitted.
